core_run_sequencer: RTL
=======================

# core_run_sequencer

Host-side initiator for the processor core's `req`/`done` handshake; it drives the `reset`/`req` pins of the core top level and observes `done`. On one `start` pulse it runs each of the NPROG programs in turn: park the core in reset, pulse `req`, wait for `done`, record the cycle count. It sits beside the core in the test/FPGA wrapper and gives the bench a single start/finish point plus per-program cycle counts.

## Interface
- NPROG, 3, number of programs run per `start`; `prog_sel` counts 0..NPROG-1
- RST_CYCLES, 2, cycles `core_reset` is held high before each `req` (≥1)
- CW, 16, width of the cycle counter and of `cycles`
- TIMEOUT, 16'hFFFF, RUN-cycle limit (used only with the macro)

- clk  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high; returns the block to IDLE
- start  in  1  request a run; sampled only in IDLE
- core_done  in  1  the core's `done`
- core_reset  out  1  drives the core's `reset`
- core_req  out  1  drives the core's `req`; one-cycle pulse
- prog_sel  out  2  index of the current or last program
- busy  out  1  high in every state except IDLE
- result_valid  out  1  one-cycle pulse; `cycles` and `prog_sel` are valid
- cycles  out  CW  RUN-cycle count of the last completed program
- run_done  out  1  one-cycle pulse when the whole sequence ends
- timeout  out  1  sticky watchdog flag (macro only)

## Operation
- States:
  - IDLE: `core_reset`=1; accept `start`.
  - RST: `core_reset`=1 for RST_CYCLES cycles, then go to REQ.
  - REQ: `core_reset`=0, `core_req`=1; clear counter; go to RUN.
  - RUN: wait for `core_done`.
  - NEXT: pulse `result_valid`. If `prog_sel`==NPROG-1, go to FIN; else increment `prog_sel` and go to RST.
  - FIN: pulse `run_done`; go to IDLE.
- IDLE: on `start`=1, clear `prog_sel`, go to RST. `start` in any other state is ignored.
- RUN counting:
  - Counter increments each RUN cycle with `core_done`=0.
  - It saturates at all-ones and never wraps.
  - First RUN cycle with `core_done`=1: latch counter into `cycles`, go to NEXT.
- `core_done` is ignored outside RUN, including a stale-high value during REQ.
- `cycles` holds until the next NEXT. `prog_sel` holds after FIN until the next `start`.
- Any mid-sequence `reset` forces IDLE. The core is re-parked in reset and no `result_valid` or `run_done` is issued for the aborted run.
- `reset` and `start` in the same cycle: `reset` wins.

## Timing
- Reset values:
  - `core_reset`=1
  - `core_req`, `busy`, `result_valid`, `run_done`, `timeout` = 0
  - `prog_sel`=0, `cycles`=0
- All outputs are registered.
- `start` sampled at edge t gives `busy`=1 from t+1. `core_reset` stays high through t+RST_CYCLES.
- `core_req` is high in cycle t+RST_CYCLES+1 only, with `core_reset`=0.
- `core_done` first seen high k cycles after RUN entry gives `cycles`=k and `result_valid` one cycle later.
- Per-program overhead outside RUN: RST_CYCLES+2 cycles.

## Configuration
- `CORE_SEQ_TIMEOUT_EN` defined:
  - If the counter reaches TIMEOUT in RUN, set `timeout`=1 and latch `cycles`=TIMEOUT.
  - Pulse `result_valid`, skip the remaining programs, go to FIN.
  - `timeout` clears only on `reset` or the next accepted `start`.
- Undefined: no watchdog. RUN waits indefinitely and `timeout` is tied 0.

## Structure
- Package `core_seq_pkg`: state enum (`IDLE`, `RST`, `REQ`, `RUN`, `NEXT`, `FIN`) and default constants for NPROG, RST_CYCLES and CW.
- One sub-module, `seq_cycle_counter`: CW-bit counter with clear, enable, saturate and a terminal-compare output against TIMEOUT.
- The FSM and output registers stay in the top module.

## Test plan
- After `reset`: `core_reset`=1, `busy`=0, `prog_sel`=0; `core_done` pulses change nothing.
- `start` with a core model answering `done` 5, 9 and 3 cycles after `req`: three `result_valid` pulses with (prog_sel, cycles) = (0,5), (1,9), (2,3), then one `run_done`. Each `core_req` is preceded by exactly 2 `core_reset` cycles.
- `start` while `busy`, plus `core_done` held high during REQ: both ignored, and the sequence timing is unchanged.
- CW=4 with `done` after 20 cycles, macro undefined: `cycles`=15 (saturated).
- Macro defined with TIMEOUT=8 and `done` never asserted: `timeout`=1, `cycles`=8, `prog_sel`=0, `run_done` pulses, state returns to IDLE.
- `reset` asserted in RUN of program 1: IDLE next cycle, `core_reset`=1, no `run_done`. A new `start` then begins at `prog_sel`=0.

Source files
------------

// File: rtl/core_seq_pkg.sv
// Shared types and default constants for the core run sequencer.
package core_seq_pkg;
  typedef enum logic [2:0] {
    IDLE,
    RST,
    REQ,
    RUN,
    NEXT,
    FIN
  } state_t;

  localparam int NPROG_DEF      = 3;
  localparam int RST_CYCLES_DEF = 2;
  localparam int CW_DEF         = 16;
endpackage

// File: rtl/seq_cycle_counter.sv
// Saturating RUN-cycle counter with clear, enable and a terminal compare.
module seq_cycle_counter #(
  parameter int          CW      = 16,
  parameter int unsigned TIMEOUT = 32'hFFFF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          term
);
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + CW'(1);
    end
  end

  assign term = (count == TERM);
endmodule

// File: rtl/core_run_sequencer.sv
// Runs NPROG programs on the core via reset/req/done, recording cycles.
// Optional watchdog: define CORE_SEQ_TIMEOUT_EN.
module core_run_sequencer
  import core_seq_pkg::*;
#(
  parameter int          NPROG      = NPROG_DEF,
  parameter int          RST_CYCLES = RST_CYCLES_DEF,
  parameter int          CW         = CW_DEF,
  parameter int unsigned TIMEOUT    = 32'hFFFF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          core_done,
  output logic          core_reset,
  output logic          core_req,
  output logic [1:0]    prog_sel,
  output logic          busy,
  output logic          result_valid,
  output logic [CW-1:0] cycles,
  output logic          run_done,
  output logic          timeout
);
  localparam logic [1:0] LAST     = 2'(NPROG - 1);
  localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);

  state_t        state;
  logic [7:0]    rcnt;
  logic [CW-1:0] count;
  logic          term;
  logic          stop;

  seq_cycle_counter #(
    .CW      (CW),
    .TIMEOUT (TIMEOUT)
  ) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == REQ),
    .enable ((state == RUN) && !core_done),
    .count  (count),
    .term   (term)
  );

`ifdef CORE_SEQ_TIMEOUT_EN
  assign stop = timeout;
`else
  logic unused_term;
  assign unused_term = term;
  assign stop        = 1'b0;
  assign timeout     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rcnt         <= '0;
      core_reset   <= 1'b1;
      core_req     <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      run_done     <= 1'b0;
      prog_sel     <= '0;
      cycles       <= '0;
`ifdef CORE_SEQ_TIMEOUT_EN
      timeout      <= 1'b0;
`endif
    end else begin
      core_req     <= 1'b0;
      result_valid <= 1'b0;
      run_done     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= RST;
            busy     <= 1'b1;
            prog_sel <= '0;
            rcnt     <= '0;
`ifdef CORE_SEQ_TIMEOUT_EN
            timeout  <= 1'b0;
`endif
          end
        end
        RST: begin
          if (rcnt == RST_LAST) begin
            state      <= REQ;
            core_reset <= 1'b0;
            core_req   <= 1'b1;
          end else begin
            rcnt <= rcnt + 8'd1;
          end
        end
        REQ: state <= RUN;
        RUN: begin
          if (core_done) begin
            cycles       <= count;
            result_valid <= 1'b1;
            state        <= NEXT;
          end
`ifdef CORE_SEQ_TIMEOUT_EN
          else if (term) begin
            cycles       <= count;
            timeout      <= 1'b1;
            result_valid <= 1'b1;
            state        <= NEXT;
          end
`endif
        end
        NEXT: begin
          if ((prog_sel == LAST) || stop) begin
            state    <= FIN;
            run_done <= 1'b1;
          end else begin
            state      <= RST;
            prog_sel   <= prog_sel + 2'd1;
            rcnt       <= '0;
            core_reset <= 1'b1;
          end
        end
        FIN: begin
          state      <= IDLE;
          busy       <= 1'b0;
          core_reset <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
